// File: rtl/fpu_op_sequencer_if.sv
// rtl/fpu_op_sequencer_if.sv - request, FPU and response signal bundle for fpu_op_sequencer
interface fpu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [1:0]  fu_funct;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic        fu_start;
    logic [31:0] fu_result;
    logic        fu_div_fin;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_funct;
    logic        rsp_timeout;
    logic        busy;

    // slave: the sequencer; master: the requester, FPU and response consumer around it
    modport slave (
        input  req_valid, req_funct, req_a, req_b, fu_result, fu_div_fin, rsp_ready,
        output req_ready, fu_funct, fu_a, fu_b, fu_start,
               rsp_valid, rsp_result, rsp_funct, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_funct, req_a, req_b, fu_result, fu_div_fin, rsp_ready,
        input  req_ready, fu_funct, fu_a, fu_b, fu_start,
               rsp_valid, rsp_result, rsp_funct, rsp_timeout, busy
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - one-at-a-time FPU operation sequencer with divide timeout
module fpu_op_sequencer #(
    parameter int ADD_LAT     = 2,
    parameter int MUL_LAT     = 1,
    parameter int DIV_TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    fpu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0]  ADD_LOAD = 8'(ADD_LAT - 1);
    localparam logic [7:0]  MUL_LOAD = 8'(MUL_LAT - 1);
    localparam logic [7:0]  DIV_LAST = 8'(DIV_TIMEOUT - 1);
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    state_t      state;
    logic [7:0]  cnt;
    logic        req_ready;
    logic        busy;
    logic        fu_start;
    logic [1:0]  fu_funct;
    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_funct;
    logic        rsp_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            fu_start    <= 1'b0;
            fu_funct    <= '0;
            fu_a        <= '0;
            fu_b        <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_funct   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        fu_funct  <= bus.req_funct;
                        fu_a      <= bus.req_a;
                        fu_b      <= bus.req_b;
                        fu_start  <= 1'b1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    fu_start <= 1'b0;
                    case (fu_funct)
                        2'd2:    cnt <= '0;
                        2'd3:    cnt <= MUL_LOAD;
                        default: cnt <= ADD_LOAD;
                    endcase
                    state <= WAIT;
                end
                WAIT: begin
                    if (fu_funct == 2'd2) begin
                        // cnt==0 masks a finish flag left over from the previous divide
                        if (cnt != 8'd0 && bus.fu_div_fin) begin
                            rsp_result  <= bus.fu_result;
                            rsp_timeout <= 1'b0;
                            rsp_funct   <= fu_funct;
                            rsp_valid   <= 1'b1;
                            state       <= DONE;
                        end else if (cnt == DIV_LAST) begin
                            rsp_result  <= QNAN;
                            rsp_timeout <= 1'b1;
                            rsp_funct   <= fu_funct;
                            rsp_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end else if (cnt == 8'd0) begin
                        rsp_result <= bus.fu_result;
                        rsp_funct  <= fu_funct;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.busy        = busy;
    assign bus.fu_start    = fu_start;
    assign bus.fu_funct    = fu_funct;
    assign bus.fu_a        = fu_a;
    assign bus.fu_b        = fu_b;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_result  = rsp_result;
    assign bus.rsp_funct   = rsp_funct;
    assign bus.rsp_timeout = rsp_timeout;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb/tb_fpu_op_sequencer.sv - scoreboard bench for fpu_op_sequencer
module tb_fpu_op_sequencer;
    localparam int ADD_LAT     = 2;
    localparam int MUL_LAT     = 1;
    localparam int DIV_TIMEOUT = 64;
    localparam int NO_FIN      = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_op_sequencer_if bus();

    fpu_op_sequencer #(
        .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  funct;
        logic [31:0] result;
        logic        timeout;
        int          cycle;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   force_hold = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response for an op accepted at posedge number acc; k is the WAIT-cycle
    // index (0 = first WAIT cycle) at which the divider finish flag is presented.
    function automatic exp_t model(input logic [1:0] f, input logic [31:0] res, input int k, input int acc);
        exp_t e;
        e.funct   = f;
        e.result  = res;
        e.timeout = 1'b0;
        case (f)
            2'd0, 2'd1: e.cycle = acc + 1 + ADD_LAT;
            2'd3:       e.cycle = acc + 1 + MUL_LAT;
            default: begin
                if (k >= 1 && k <= DIV_TIMEOUT - 1) begin
                    e.cycle = acc + 2 + k;
                end else begin
                    e.result  = 32'h7FC0_0000;
                    e.timeout = 1'b1;
                    e.cycle   = acc + 1 + DIV_TIMEOUT;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int k, input bit stale, input bit poke);
        int acc;
        int waited = 0;
        int last;
        @(negedge clk);
        bus.req_funct = f;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: req_ready still 0 after %0d cycles, required 1", waited);
            bus.req_valid = 1'b0;
            return;
        end
        bus.fu_result  = res;
        bus.fu_div_fin = (f == 2'd2) ? stale : 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = cyc;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        expq.push_back(model(f, res, k, acc));
        check("issue_start", bus.fu_start, 1);
        check("issue_funct", bus.fu_funct, f);
        check("issue_a", bus.fu_a, a);
        check("issue_b", bus.fu_b, b);
        check("issue_busy", bus.busy, 1);
        check("issue_req_ready", bus.req_ready, 0);
        if (f == 2'd2) last = (k >= 1 && k <= DIV_TIMEOUT - 1) ? k : DIV_TIMEOUT - 1;
        else           last = 0;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (f == 2'd2) bus.fu_div_fin = (i == k) || (stale && i == 0);
            if (i == 0) begin
                check("wait_start_low", bus.fu_start, 0);
                if (poke) begin
                    bus.req_valid = 1'b1;
                    bus.req_funct = 2'($urandom);
                    check("wait_req_ready", bus.req_ready, 0);
                end
            end else begin
                bus.req_valid = 1'b0;
            end
            if (i == last) check("wait_a_held", bus.fu_a, a);
        end
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.fu_div_fin = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((expq.size() != 0 || !bus.req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", expq.size());
        end
    endtask

    // Response monitor / scoreboard
    initial begin
        bit   in_rsp = 1'b0;
        int   hold   = 0;
        exp_t cur;
        cur = '{2'd0, 32'd0, 1'b0, 0};
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_rsp = 1'b0;
                bus.rsp_ready = 1'b0;
            end else if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: rsp_valid=1 result %h, required no response", bus.rsp_result);
                    end else begin
                        cur = expq.pop_front();
                        check("rsp_cycle", cyc, cur.cycle);
                    end
                    if (force_hold >= 0) begin
                        hold = force_hold;
                        force_hold = -1;
                    end else begin
                        hold = $urandom_range(0, 5);
                    end
                end
                check("rsp_result", bus.rsp_result, cur.result);
                check("rsp_funct", bus.rsp_funct, cur.funct);
                check("rsp_timeout", bus.rsp_timeout, cur.timeout);
                check("rsp_req_ready", bus.req_ready, 0);
                if (hold == 0) begin
                    bus.rsp_ready = 1'b1;
                end else begin
                    hold--;
                    bus.rsp_ready = 1'b0;
                end
            end else begin
                in_rsp = 1'b0;
                bus.rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_funct  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.fu_result  = '0;
        bus.fu_div_fin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", bus.req_ready, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_fu_start", bus.fu_start, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_fu_a", bus.fu_a, 0);
        check("reset_rsp_result", bus.rsp_result, 0);
        rst = 1'b0;

        run_op(2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 1'b0, 1'b0);
        wait_idle();
        force_hold = 5;
        run_op(2'd3, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 0, 1'b0, 1'b0);
        run_op(2'd1, 32'h40A0_0000, 32'h3F80_0000, 32'h4080_0000, 0, 1'b0, 1'b0);
        run_op(2'd2, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 9, 1'b1, 1'b0);
        run_op(2'd2, 32'h3F80_0000, 32'h0000_0000, 32'h1234_5678, NO_FIN, 1'b0, 1'b0);
        run_op(2'd2, 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, DIV_TIMEOUT - 1, 1'b0, 1'b1);
        run_op(2'd2, 32'h4000_0000, 32'h4080_0000, 32'h3E80_0000, 0, 1'b1, 1'b1);
        run_op(2'd2, 32'h4000_0000, 32'h4080_0000, 32'h3E80_0000, 1, 1'b0, 1'b0);
        wait_idle();

        // reset during the WAIT of a divide: no response may follow
        @(negedge clk);
        bus.fu_div_fin = 1'b0;
        bus.req_funct  = 2'd2;
        bus.req_a      = 32'hDEAD_BEEF;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_req_ready", bus.req_ready, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_fu_start", bus.fu_start, 0);
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_fu_a", bus.fu_a, 0);
        repeat (DIV_TIMEOUT + 10) @(negedge clk);
        check("midrst_idle", bus.busy, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] f;
            f = 2'($urandom);
            run_op(f, $urandom, $urandom, $urandom, $urandom_range(0, DIV_TIMEOUT + 5),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("final_queue_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
